// File: rtl/mbist_repair_sched.sv
// mbist_repair_sched: round-robin collector of MBIST error reports that
// deduplicates failing addresses and programs unique ones into the repair
// address table through a single write port.
//
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   sched_en        - allow new grants (in-flight transaction always completes)
//   rep_clr         - synchronous clear of table, count and fail flag
//   err_req/err_addr- per-engine report request and failing address slice
//   err_ack         - one-cycle acknowledge to the served engine
//   rep_wr_en/idx/addr - repair table write strobe, entry index, address
//   rep_cnt         - allocated entry count (saturates at BIST_ERR_LIMIT)
//   rep_fail        - sticky: unique error seen while the table was full
//   sched_busy      - scheduler is not idle
module mbist_repair_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BIST_ADDR_WD   = 9,
  parameter int unsigned BIST_ERR_LIMIT = 4,
  parameter int unsigned CNT_WD         = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sched_en,
  input  logic                            rep_clr,
  input  logic [NUM_REQ-1:0]              err_req,
  input  logic [NUM_REQ*BIST_ADDR_WD-1:0] err_addr,
  output logic [NUM_REQ-1:0]              err_ack,
  output logic                            rep_wr_en,
  output logic [CNT_WD-1:0]               rep_wr_idx,
  output logic [BIST_ADDR_WD-1:0]         rep_wr_addr,
  output logic [CNT_WD-1:0]               rep_cnt,
  output logic                            rep_fail,
  output logic                            sched_busy
);

  localparam int unsigned PTR_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_COMMIT} state_e;
  typedef enum logic [1:0] {RES_HIT, RES_MISS, RES_FULL} res_e;

  state_e                  state_q, state_d;
  res_e                    res_q, res_d;
  logic [PTR_WD-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_WD-1:0]       grant_q, grant_d;
  logic [BIST_ADDR_WD-1:0] lat_addr_q, lat_addr_d;
  logic [NUM_REQ-1:0]      last_ack_q, last_ack_d;
  logic [NUM_REQ-1:0]      err_ack_q, err_ack_d;
  logic                    rep_wr_en_q, rep_wr_en_d;
  logic [CNT_WD-1:0]       rep_wr_idx_q, rep_wr_idx_d;
  logic [BIST_ADDR_WD-1:0] rep_wr_addr_q, rep_wr_addr_d;
  logic [CNT_WD-1:0]       rep_cnt_q, rep_cnt_d;
  logic                    rep_fail_q, rep_fail_d;
  logic                    sched_busy_q, sched_busy_d;
  logic [BIST_ADDR_WD-1:0] entry_q [BIST_ERR_LIMIT];
  logic [BIST_ADDR_WD-1:0] entry_d [BIST_ERR_LIMIT];
  logic [BIST_ERR_LIMIT-1:0] valid_q, valid_d;

  logic [NUM_REQ-1:0]      req_eff;
  logic [PTR_WD-1:0]       cand;
  logic                    gnt_vld;
  logic [PTR_WD-1:0]       gnt_idx;
  logic [BIST_ADDR_WD-1:0] gnt_addr;
  logic                    hit;

  // Round-robin pick; the engine acked in the last COMMIT is masked for one
  // IDLE cycle because it may still be dropping its request.
  always_comb begin
    req_eff  = err_req & ~last_ack_q;
    cand     = '0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_WD'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_vld && req_eff[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (PTR_WD'(k) == gnt_idx) gnt_addr = err_addr[k*BIST_ADDR_WD +: BIST_ADDR_WD];
    end
  end

  // Dedup compare against allocated entries only.
  always_comb begin
    hit = 1'b0;
    for (int unsigned k = 0; k < BIST_ERR_LIMIT; k++) begin
      if (valid_q[k] && (entry_q[k] == lat_addr_q)) hit = 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    res_d         = res_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    lat_addr_d    = lat_addr_q;
    last_ack_d    = '0;
    err_ack_d     = '0;
    rep_wr_en_d   = 1'b0;
    rep_wr_idx_d  = rep_wr_idx_q;
    rep_wr_addr_d = rep_wr_addr_q;
    rep_cnt_d     = rep_cnt_q;
    rep_fail_d    = rep_fail_q;
    entry_d       = entry_q;
    valid_d       = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (sched_en && gnt_vld) begin
          grant_d    = gnt_idx;
          lat_addr_d = gnt_addr;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_COMMIT;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          err_ack_d[k] = (PTR_WD'(k) == grant_q);
        end
        if (hit) begin
          res_d = RES_HIT;
        end else if (rep_cnt_q < CNT_WD'(BIST_ERR_LIMIT)) begin
          res_d         = RES_MISS;
          rep_wr_en_d   = 1'b1;
          rep_wr_idx_d  = rep_cnt_q;
          rep_wr_addr_d = lat_addr_q;
        end else begin
          res_d = RES_FULL;
        end
      end
      ST_COMMIT: begin
        state_d    = ST_IDLE;
        last_ack_d = err_ack_q;
        rr_ptr_d   = (grant_q == PTR_WD'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        if (res_q == RES_MISS) begin
          for (int unsigned k = 0; k < BIST_ERR_LIMIT; k++) begin
            if (CNT_WD'(k) == rep_cnt_q) begin
              entry_d[k] = lat_addr_q;
              valid_d[k] = 1'b1;
            end
          end
          rep_cnt_d = rep_cnt_q + 1'b1;
        end else if (res_q == RES_FULL) begin
          rep_fail_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sched_busy_d = (state_d != ST_IDLE);
  end

  // Reset and rep_clr share the same effect; an in-flight transaction is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || rep_clr) begin
      state_q       <= ST_IDLE;
      res_q         <= RES_HIT;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      lat_addr_q    <= '0;
      last_ack_q    <= '0;
      err_ack_q     <= '0;
      rep_wr_en_q   <= 1'b0;
      rep_wr_idx_q  <= '0;
      rep_wr_addr_q <= '0;
      rep_cnt_q     <= '0;
      rep_fail_q    <= 1'b0;
      sched_busy_q  <= 1'b0;
      valid_q       <= '0;
      for (int unsigned k = 0; k < BIST_ERR_LIMIT; k++) entry_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      res_q         <= res_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      lat_addr_q    <= lat_addr_d;
      last_ack_q    <= last_ack_d;
      err_ack_q     <= err_ack_d;
      rep_wr_en_q   <= rep_wr_en_d;
      rep_wr_idx_q  <= rep_wr_idx_d;
      rep_wr_addr_q <= rep_wr_addr_d;
      rep_cnt_q     <= rep_cnt_d;
      rep_fail_q    <= rep_fail_d;
      sched_busy_q  <= sched_busy_d;
      valid_q       <= valid_d;
      entry_q       <= entry_d;
    end
  end

  assign err_ack     = err_ack_q;
  assign rep_wr_en   = rep_wr_en_q;
  assign rep_wr_idx  = rep_wr_idx_q;
  assign rep_wr_addr = rep_wr_addr_q;
  assign rep_cnt     = rep_cnt_q;
  assign rep_fail    = rep_fail_q;
  assign sched_busy  = sched_busy_q;

endmodule

// File: tb/tb_mbist_repair_sched.sv
// tb_mbist_repair_sched: directed plus randomized reports checked every cycle
// against a transaction-level reference (table as a queue of addresses).
module tb_mbist_repair_sched;

  localparam int N = 4;
  localparam int W = 9;
  localparam int L = 4;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst_n, sched_en, rep_clr;
  logic [N-1:0]   err_req;
  logic [N*W-1:0] err_addr;
  logic [N-1:0]   err_ack;
  logic           rep_wr_en;
  logic [C-1:0]   rep_wr_idx;
  logic [W-1:0]   rep_wr_addr;
  logic [C-1:0]   rep_cnt;
  logic           rep_fail;
  logic           sched_busy;

  mbist_repair_sched #(.NUM_REQ(N), .BIST_ADDR_WD(W), .BIST_ERR_LIMIT(L), .CNT_WD(C)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .rep_clr(rep_clr),
    .err_req(err_req), .err_addr(err_addr), .err_ack(err_ack),
    .rep_wr_en(rep_wr_en), .rep_wr_idx(rep_wr_idx), .rep_wr_addr(rep_wr_addr),
    .rep_cnt(rep_cnt), .rep_fail(rep_fail), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: table contents, sticky fail, rr pointer, one in-flight report.
  logic [W-1:0] tbl[$];
  bit           m_fail;
  bit           pend_fail;
  int           rr;
  int           blocked;
  int           txn_eng;
  int           txn_age;
  logic [W-1:0] txn_addr;
  logic [N-1:0] e_ack;
  logic         e_wr;
  logic [C-1:0] e_idx;
  logic [W-1:0] e_waddr;
  logic [N-1:0] ack_prev, ack_prev2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int e, input logic [W-1:0] a);
    err_req[e]          = 1'b1;
    err_addr[e*W +: W]  = a;
  endtask

  task automatic model_edge(input logic s_rst, input logic s_clr, input logic s_en,
                            input logic [N-1:0] s_req, input logic [N*W-1:0] s_addr);
    int nb;
    bit hit;
    int c;
    if (!s_rst || s_clr) begin
      tbl.delete();
      m_fail = 0; pend_fail = 0; rr = 0; blocked = -1; txn_eng = -1;
      e_ack = '0; e_wr = 0; e_idx = '0; e_waddr = '0;
      return;
    end
    nb = -1;
    if (txn_eng >= 0 && txn_age == 1) begin
      hit = 0;
      foreach (tbl[k]) if (tbl[k] == txn_addr) hit = 1;
      e_ack = '0; e_ack[txn_eng] = 1'b1;
      e_wr = 0; pend_fail = 0;
      if (!hit && tbl.size() < L) begin
        e_wr = 1; e_idx = C'(tbl.size()); e_waddr = txn_addr;
      end else if (!hit) begin
        pend_fail = 1;
      end
      txn_age = 2;
    end else if (txn_eng >= 0) begin
      if (e_wr) tbl.push_back(txn_addr);
      if (pend_fail) m_fail = 1;
      rr = (txn_eng + 1) % N;
      nb = txn_eng;
      txn_eng = -1;
      e_ack = '0; e_wr = 0;
    end else if (s_en) begin
      for (int i = 0; i < N; i++) begin
        c = (rr + i) % N;
        if (s_req[c] && c != blocked) begin
          txn_eng = c; txn_addr = s_addr[c*W +: W]; txn_age = 1;
          break;
        end
      end
    end
    blocked = nb;
  endtask

  // One clock: advance the reference with the inputs the DUT sampled, compare
  // after the edge, then let engines drop requests acked two cycles back.
  task automatic step();
    logic s_rst, s_clr, s_en;
    logic [N-1:0] s_req;
    logic [N*W-1:0] s_addr;
    s_rst = rst_n; s_clr = rep_clr; s_en = sched_en; s_req = err_req; s_addr = err_addr;
    @(posedge clk);
    model_edge(s_rst, s_clr, s_en, s_req, s_addr);
    #1;
    chk("err_ack", 32'(err_ack), 32'(e_ack));
    chk("rep_wr_en", 32'(rep_wr_en), 32'(e_wr));
    chk("rep_wr_idx", 32'(rep_wr_idx), 32'(e_idx));
    chk("rep_wr_addr", 32'(rep_wr_addr), 32'(e_waddr));
    chk("rep_cnt", 32'(rep_cnt), 32'(tbl.size()));
    chk("rep_fail", 32'(rep_fail), 32'(m_fail));
    chk("sched_busy", 32'(sched_busy), 32'(txn_eng >= 0));
    err_req   = err_req & ~ack_prev2;
    ack_prev2 = ack_prev;
    ack_prev  = e_ack;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; sched_en = 1'b1; rep_clr = 1'b0;
    err_req = '0; err_addr = '0; ack_prev = '0; ack_prev2 = '0;
    tbl.delete(); m_fail = 0; pend_fail = 0; rr = 0; blocked = -1; txn_eng = -1; txn_age = 0;
    txn_addr = '0; e_ack = '0; e_wr = 0; e_idx = '0; e_waddr = '0;
    #1;
    run(2);
    rst_n = 1'b1;
    run(1);

    // Single report
    raise(0, 9'h010);
    run(6);
    chk("single_cnt", 32'(rep_cnt), 32'd1);
    chk("single_idx_hold", 32'(rep_wr_addr), 32'h010);

    // Duplicate from another engine
    raise(2, 9'h010);
    run(6);
    chk("dup_cnt", 32'(rep_cnt), 32'd1);

    // Simultaneous requests after a clear
    rep_clr = 1'b1; run(1); rep_clr = 1'b0;
    for (int e = 0; e < N; e++) raise(e, 9'(e + 1));
    run(16);
    chk("rr_cnt", 32'(rep_cnt), 32'd4);
    chk("rr_last_addr", 32'(rep_wr_addr), 32'h004);

    // Overflow, then fail stays set over a duplicate
    raise(1, 9'h1F0);
    run(6);
    chk("ovf_fail", 32'(rep_fail), 32'd1);
    chk("ovf_cnt", 32'(rep_cnt), 32'd4);
    raise(3, 9'h002);
    run(6);
    chk("ovf_sticky", 32'(rep_fail), 32'd1);

    // sched_en low holds off grants
    sched_en = 1'b0;
    raise(1, 9'h033);
    run(4);
    chk("en_low_idle", 32'(sched_busy), 32'd0);
    sched_en = 1'b1;
    run(6);

    // Clear while in CHECK
    rep_clr = 1'b1; run(1); rep_clr = 1'b0;
    raise(3, 9'h0AA);
    run(1);
    rep_clr = 1'b1; run(1); rep_clr = 1'b0;
    chk("clr_cnt", 32'(rep_cnt), 32'd0);
    chk("clr_fail", 32'(rep_fail), 32'd0);
    run(8);
    chk("clr_regrant_cnt", 32'(rep_cnt), 32'd1);
    chk("clr_regrant_addr", 32'(rep_wr_addr), 32'h0AA);

    // Reset during COMMIT
    raise(0, 9'h055);
    run(2);
    rst_n = 1'b0; run(1); rst_n = 1'b1;
    chk("rst_cnt", 32'(rep_cnt), 32'd0);
    chk("rst_wr_addr", 32'(rep_wr_addr), 32'd0);
    run(8);

    // Randomized traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      rep_clr  = ($urandom_range(0, 89) == 0);
      sched_en = ($urandom_range(0, 7) != 0);
      for (int e = 0; e < N; e++) begin
        if (!err_req[e] && $urandom_range(0, 3) == 0)
          raise(e, ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511)));
      end
      step();
    end
    rst_n = 1'b1; rep_clr = 1'b0; sched_en = 1'b1;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
